// File: rtl/axi_multi_adder_pkg.sv
// Shared definitions for the AXI4-Lite multi-operand adder: register map,
// CTRL/STATUS bit positions, response codes and the sequencer state type.
package axi_multi_adder_pkg;

   localparam int CTRL_START  = 0;
   localparam int CTRL_SAT    = 1;
   localparam int CTRL_SIGNED = 2;
   localparam int CTRL_IRQ_EN = 3;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_OVF  = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUM  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Byte offsets of the register map; operands first, then control block.
   function automatic int unsigned op_offset(input int unsigned idx);
      return 4 * idx;
   endfunction

   function automatic int unsigned ctrl_offset(input int unsigned num_ops);
      return 4 * num_ops;
   endfunction

   function automatic int unsigned status_offset(input int unsigned num_ops);
      return 4 * num_ops + 4;
   endfunction

   function automatic int unsigned result_offset(input int unsigned num_ops);
      return 4 * num_ops + 8;
   endfunction

endpackage

// File: rtl/axi_multi_adder_core.sv
// Sequencer that sums the operand registers one per cycle into a widened
// accumulator, then produces a wrapped or saturated 32-bit result.
module axi_multi_adder_core
   import axi_multi_adder_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_OPS = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           sat_mode,
   input  logic                           signed_mode,
   input  logic                           done_clr,
   input  logic [NUM_OPS-1:0][DATA_W-1:0] ops,
   output logic                           busy,
   output logic                           done,
   output logic                           overflow,
   output logic [DATA_W-1:0]              result
);

   localparam int ACC_W = DATA_W + $clog2(NUM_OPS);
   localparam int KW    = $clog2(NUM_OPS);

   state_t                    state, state_nxt;
   logic [KW-1:0]             k;
   logic                      sat_q, signed_q;
   logic signed [ACC_W-1:0]   acc, acc_sum;
   logic                      last_op;

   function automatic logic signed [ACC_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                       input logic sgn);
      return {{(ACC_W-DATA_W){sgn & v[DATA_W-1]}}, v};
   endfunction

   // Signed range holds only when all bits from DATA_W-1 upward agree.
   function automatic logic range_ovf(input logic signed [ACC_W-1:0] a, input logic sgn);
      if (sgn)
         return !((&a[ACC_W-1:DATA_W-1]) || !(|a[ACC_W-1:DATA_W-1]));
      else
         return |a[ACC_W-1:DATA_W];
   endfunction

   function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] a,
                                                  input logic sat, input logic sgn);
      if (sat && range_ovf(a, sgn)) begin
         if (!sgn)
            return {DATA_W{1'b1}};
         else if (a[ACC_W-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
         else
            return {1'b0, {(DATA_W-1){1'b1}}};
      end
      return a[DATA_W-1:0];
   endfunction

   assign acc_sum = acc + extend(ops[k], signed_q);
   assign last_op = (k == KW'(NUM_OPS - 1));
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_SUM;
         ST_SUM:  if (last_op) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The final add feeds the result register directly, so RESULT and done
   // are already valid during the DONE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k        <= '0;
         acc      <= '0;
         sat_q    <= 1'b0;
         signed_q <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         result   <= '0;
      end else if (start && state == ST_IDLE) begin
         k        <= '0;
         acc      <= '0;
         sat_q    <= sat_mode;
         signed_q <= signed_mode;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else if (state == ST_SUM) begin
         acc <= acc_sum;
         k   <= k + KW'(1);
         if (last_op) begin
            result   <= saturate(acc_sum, sat_q, signed_q);
            overflow <= range_ovf(acc_sum, signed_q);
            done     <= 1'b1;
         end else if (done_clr) begin
            done <= 1'b0;
         end
      end else if (done_clr) begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/axi_multi_adder.sv
// AXI4-Lite register front end for the multi-operand adder: operand, control,
// status and result registers around the summing core.
module axi_multi_adder
   import axi_multi_adder_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 7,
   parameter int NUM_OPS            = 4
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0]                    S_AXI_AWPROT,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0]                    S_AXI_ARPROT,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic                          irq
);

   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int DW = C_S_AXI_DATA_WIDTH;

   logic [NUM_OPS-1:0][DW-1:0] ops;
   logic                       ctrl_sat, ctrl_signed, ctrl_irq_en;
   logic                       busy, done, overflow;
   logic [DW-1:0]              result;
   logic                       wr_fire, rd_fire;
   logic [AW-1:0]              wr_base, rd_base;
   logic                       wr_is_op, wr_is_ctrl, wr_is_status;
   logic                       wr_err, start, done_clr;
   logic [DW-1:0]              rd_mux;
   logic                       unused_bits;

   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign wr_fire = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
   assign rd_fire = S_AXI_ARREADY & S_AXI_ARVALID;
   assign wr_base = {S_AXI_AWADDR[AW-1:2], 2'b00};
   assign rd_base = {S_AXI_ARADDR[AW-1:2], 2'b00};

   always_comb begin
      wr_is_op = 1'b0;
      for (int i = 0; i < NUM_OPS; i++)
         if (wr_base == AW'(op_offset(i))) wr_is_op = 1'b1;
   end

   assign wr_is_ctrl   = (wr_base == AW'(ctrl_offset(NUM_OPS)));
   assign wr_is_status = (wr_base == AW'(status_offset(NUM_OPS)));
   assign wr_err       = (wr_is_op | wr_is_ctrl) & busy;
   assign start        = wr_fire & wr_is_ctrl & ~busy & S_AXI_WSTRB[0] & S_AXI_WDATA[CTRL_START];
   assign done_clr     = wr_fire & wr_is_status & S_AXI_WSTRB[0] & S_AXI_WDATA[STAT_DONE];
   assign irq          = done & ctrl_irq_en;

   // Write channel: address and data are taken together, one transaction
   // outstanding, so the ready pulse is blocked while a response is pending.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= RESP_OKAY;
      end else begin
         if (!S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID) begin
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
         end else begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
         end
         if (wr_fire) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
         end else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         ops         <= '0;
         ctrl_sat    <= 1'b0;
         ctrl_signed <= 1'b0;
         ctrl_irq_en <= 1'b0;
      end else if (wr_fire && !busy) begin
         for (int i = 0; i < NUM_OPS; i++)
            if (wr_base == AW'(op_offset(i)))
               for (int b = 0; b < DW/8; b++)
                  if (S_AXI_WSTRB[b]) ops[i][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
         if (wr_is_ctrl && S_AXI_WSTRB[0]) begin
            ctrl_sat    <= S_AXI_WDATA[CTRL_SAT];
            ctrl_signed <= S_AXI_WDATA[CTRL_SIGNED];
            ctrl_irq_en <= S_AXI_WDATA[CTRL_IRQ_EN];
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_OPS; i++)
         if (rd_base == AW'(op_offset(i))) rd_mux = ops[i];
      if (rd_base == AW'(ctrl_offset(NUM_OPS))) begin
         rd_mux[CTRL_SAT]    = ctrl_sat;
         rd_mux[CTRL_SIGNED] = ctrl_signed;
         rd_mux[CTRL_IRQ_EN] = ctrl_irq_en;
      end
      if (rd_base == AW'(status_offset(NUM_OPS))) begin
         rd_mux[STAT_BUSY] = busy;
         rd_mux[STAT_DONE] = done;
         rd_mux[STAT_OVF]  = overflow;
      end
      if (rd_base == AW'(result_offset(NUM_OPS))) rd_mux = result;
   end

   // Read channel: RDATA is captured at the handshake and held until RREADY.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RRESP   <= RESP_OKAY;
         S_AXI_RDATA   <= '0;
      end else begin
         S_AXI_ARREADY <= !S_AXI_ARREADY && S_AXI_ARVALID && !S_AXI_RVALID;
         if (rd_fire) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_mux;
            S_AXI_RRESP  <= RESP_OKAY;
         end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
         end
      end
   end

   axi_multi_adder_core #(
      .DATA_W  (DW),
      .NUM_OPS (NUM_OPS)
   ) u_core (
      .clk         (ACLK),
      .rst         (ARESET),
      .start       (start),
      .sat_mode    (S_AXI_WDATA[CTRL_SAT]),
      .signed_mode (S_AXI_WDATA[CTRL_SIGNED]),
      .done_clr    (done_clr),
      .ops         (ops),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .result      (result)
   );

endmodule

// File: tb/tb_axi_multi_adder.sv
// Bench for axi_multi_adder (NUM_OPS=4): directed vectors, timing corner
// cases and random sums checked against a plain-arithmetic model.
module tb_axi_multi_adder;

   logic        ACLK = 1'b0;
   logic        ARESET = 1'b0;
   logic [6:0]  S_AXI_AWADDR = '0;
   logic [2:0]  S_AXI_AWPROT = '0;
   logic        S_AXI_AWVALID = 1'b0;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA = '0;
   logic [3:0]  S_AXI_WSTRB = '0;
   logic        S_AXI_WVALID = 1'b0;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY = 1'b0;
   logic [6:0]  S_AXI_ARADDR = '0;
   logic [2:0]  S_AXI_ARPROT = '0;
   logic        S_AXI_ARVALID = 1'b0;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY = 1'b0;
   logic        irq;

   localparam logic [6:0] CTRL_A = 7'h10;
   localparam logic [6:0] STAT_A = 7'h14;
   localparam logic [6:0] RES_A  = 7'h18;
   localparam logic [6:0] UNMAP  = 7'h40;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int unstable = 0;

   axi_multi_adder dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .irq(irq)
   );

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int hold, output logic [1:0] resp);
      int n;
      S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
      n = 0;
      do begin @(posedge ACLK); #1; n++; end while (!S_AXI_AWREADY && n < 20);
      chk("awready_seen", {31'b0, S_AXI_AWREADY}, 32'd1);
      @(posedge ACLK); #1;
      hs_cyc = cyc;
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      chk("bvalid_after_hs", {31'b0, S_AXI_BVALID}, 32'd1);
      resp = S_AXI_BRESP;
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
         if (!S_AXI_BVALID || S_AXI_BRESP !== resp || S_AXI_AWREADY || S_AXI_WREADY) unstable++;
         @(posedge ACLK); #1;
      end
      S_AXI_BREADY = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [6:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
      int n;
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
      n = 0;
      do begin @(posedge ACLK); #1; n++; end while (!S_AXI_ARREADY && n < 20);
      chk("arready_seen", {31'b0, S_AXI_ARREADY}, 32'd1);
      @(posedge ACLK); #1;
      S_AXI_ARVALID = 1'b0;
      chk("rvalid_after_hs", {31'b0, S_AXI_RVALID}, 32'd1);
      data = S_AXI_RDATA; resp = S_AXI_RRESP;
      unstable = 0;
      for (int i = 0; i < hold; i++) begin
         if (!S_AXI_RVALID || S_AXI_RDATA !== data || S_AXI_RRESP !== resp || S_AXI_ARREADY) unstable++;
         @(posedge ACLK); #1;
      end
      S_AXI_RREADY = 1'b1;
      @(posedge ACLK); #1;
      S_AXI_RREADY = 1'b0;
   endtask

   task automatic run_sum(input logic [3:0][31:0] opv, input logic [3:0] ctrl,
                          output logic [31:0] res, output logic [31:0] st);
      logic [1:0] r;
      int n;
      for (int i = 0; i < 4; i++) axi_write(7'(4 * i), opv[i], 4'hF, 0, r);
      axi_write(CTRL_A, {28'b0, ctrl}, 4'hF, 0, r);
      n = 0;
      do begin axi_read(STAT_A, 0, st, r); n++; end while (!st[1] && n < 30);
      chk("done_poll", {31'b0, st[1]}, 32'd1);
      axi_read(RES_A, 0, res, r);
      axi_write(STAT_A, 32'h2, 4'hF, 0, r);
   endtask

   // Reference: exact integer sum, then range test and clamp.
   function automatic void model(input logic [3:0][31:0] opv, input logic sat, input logic sgn,
                                 output logic [31:0] res, output logic ovf);
      longint s;
      s = 0;
      for (int i = 0; i < 4; i++)
         s += sgn ? longint'($signed(opv[i])) : longint'(opv[i]);
      if (sgn) ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      else     ovf = (s > 64'sd4294967295);
      if (sat && ovf) res = !sgn ? 32'hFFFFFFFF : (s < 0 ? 32'h80000000 : 32'h7FFFFFFF);
      else            res = s[31:0];
   endfunction

   function automatic logic [31:0] pick_op();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'h7FFFFFFF;
         3: return 32'h80000000;
         4: return 32'hFFFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   typedef struct packed {
      logic [3:0][31:0] op;
      logic [3:0]       ctrl;
      logic [31:0]      res;
      logic             ovf;
   } vec_t;

   vec_t vecs [7];

   initial begin
      logic [31:0] res, st, d, mres;
      logic [1:0]  r;
      logic        movf;
      logic [3:0][31:0] opv;
      logic [3:0]  ctrl;

      vecs[0] = '{op: {32'h4, 32'h3, 32'h2, 32'h1}, ctrl: 4'h1, res: 32'h0000000A, ovf: 1'b0};
      vecs[1] = '{op: {4{32'hFFFFFFFF}}, ctrl: 4'h1, res: 32'hFFFFFFFC, ovf: 1'b1};
      vecs[2] = '{op: {4{32'hFFFFFFFF}}, ctrl: 4'h3, res: 32'hFFFFFFFF, ovf: 1'b1};
      vecs[3] = '{op: {32'h0, 32'h0, 32'h1, 32'h7FFFFFFF}, ctrl: 4'h7, res: 32'h7FFFFFFF, ovf: 1'b1};
      vecs[4] = '{op: {32'h0, 32'h0, 32'hFFFFFFFF, 32'h80000000}, ctrl: 4'h7, res: 32'h80000000, ovf: 1'b1};
      vecs[5] = '{op: {4{32'hFFFFFFFF}}, ctrl: 4'h5, res: 32'hFFFFFFFC, ovf: 1'b0};
      vecs[6] = '{op: {32'h0, 32'h0, 32'h1, 32'h7FFFFFFF}, ctrl: 4'h5, res: 32'h80000000, ovf: 1'b1};

      #2 ARESET = 1'b1;
      #1;
      chk("reset_outs", {21'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                         S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP, irq, 1'b0}, 32'h0);
      chk("reset_rdata", S_AXI_RDATA, 32'h0);
      repeat (2) @(posedge ACLK);
      #1 ARESET = 1'b0;
      axi_read(STAT_A, 0, d, r);  chk("reset_status", d, 32'h0);
      axi_read(RES_A, 0, d, r);   chk("reset_result", d, 32'h0);

      for (int i = 0; i < 7; i++) begin
         run_sum(vecs[i].op, vecs[i].ctrl, res, st);
         chk($sformatf("vec%0d_result", i), res, vecs[i].res);
         chk($sformatf("vec%0d_ovf", i), {31'b0, st[2]}, {31'b0, vecs[i].ovf});
      end

      // done/irq appear in the 5th cycle after the start handshake cycle.
      for (int i = 0; i < 4; i++) axi_write(7'(4 * i), 32'(i + 1), 4'hF, 0, r);
      axi_write(CTRL_A, 32'h9, 4'hF, 0, r);
      while (cyc < hs_cyc + 3) begin @(posedge ACLK); #1; end
      chk("irq_before_latency", {31'b0, irq}, 32'd0);
      @(posedge ACLK); #1;
      chk("irq_at_latency", {31'b0, irq}, 32'd1);
      axi_read(RES_A, 0, d, r);   chk("latency_result", d, 32'h0000000A);
      axi_read(STAT_A, 0, d, r);  chk("latency_ovf_done", {30'b0, d[2:1]}, 32'h1);
      axi_write(STAT_A, 32'h2, 4'hF, 0, r);
      chk("irq_cleared", {31'b0, irq}, 32'd0);

      // Operand write while summing is rejected and leaves OP[0] intact.
      axi_write(CTRL_A, 32'h1, 4'hF, 0, r);
      axi_write(7'h00, 32'h55, 4'hF, 0, r);
      chk("busy_write_slverr", {30'b0, r}, 32'h2);
      repeat (8) @(posedge ACLK); #1;
      axi_read(7'h00, 0, d, r);   chk("busy_write_dropped", d, 32'h1);
      axi_write(STAT_A, 32'h2, 4'hF, 0, r);
      axi_read(STAT_A, 0, d, r);  chk("done_w1c", {31'b0, d[1]}, 32'd0);

      axi_write(7'h08, 32'hAABBCCDD, 4'hF, 0, r);
      axi_write(7'h08, 32'h11223344, 4'b0101, 0, r);
      axi_read(7'h08, 0, d, r);   chk("wstrb_merge", d, 32'hAA22CC44);
      axi_write(CTRL_A, 32'hE, 4'hF, 0, r);
      axi_read(CTRL_A, 0, d, r);  chk("ctrl_readback", d, 32'hE);
      axi_write(UNMAP, 32'h1234, 4'hF, 0, r);
      chk("unmapped_wr_okay", {30'b0, r}, 32'h0);
      axi_read(UNMAP, 0, d, r);   chk("unmapped_rd", {d[29:0], r}, 32'h0);

      axi_write(7'h0C, 32'hCAFEF00D, 4'hF, 10, r);
      chk("b_hold_stable", 32'(unstable), 32'h0);
      axi_read(7'h0C, 10, d, r);
      chk("r_hold_stable", 32'(unstable), 32'h0);
      chk("r_hold_data", d, 32'hCAFEF00D);

      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 4; i++) opv[i] = pick_op();
         ctrl = {1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
         model(opv, ctrl[1], ctrl[2], mres, movf);
         run_sum(opv, ctrl, res, st);
         chk($sformatf("rand%0d_result", n), res, mres);
         chk($sformatf("rand%0d_ovf", n), {31'b0, st[2]}, {31'b0, movf});
      end

      // Reset in the middle of a sum clears everything at once.
      for (int i = 0; i < 4; i++) axi_write(7'(4 * i), 32'h100 + 32'(i), 4'hF, 0, r);
      axi_read(7'h04, 0, d, r);   chk("pre_reset_op1", d, 32'h101);
      axi_write(CTRL_A, 32'hF, 4'hF, 0, r);
      ARESET = 1'b1;
      #1;
      chk("midsum_reset_outs", {21'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BRESP,
                                S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RRESP, irq, 1'b0}, 32'h0);
      chk("midsum_reset_rdata", S_AXI_RDATA, 32'h0);
      repeat (2) @(posedge ACLK);
      #1 ARESET = 1'b0;
      axi_read(STAT_A, 0, d, r);  chk("post_reset_status", d, 32'h0);
      axi_read(CTRL_A, 0, d, r);  chk("post_reset_ctrl", d, 32'h0);
      axi_read(7'h00, 0, d, r);   chk("post_reset_op0", d, 32'h0);
      axi_read(RES_A, 0, d, r);   chk("post_reset_result", d, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
